alu_sched: RTL

//  Shares the single 2-bit-command ALU between two requesters (0 = fetch/branch, 1 = execute).

---
 rtl/alu_sched_if.sv | 44 ++++
 rtl/alu_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched_if
//  Description : Request/response bundle between the control path and the
//                ALU scheduler.
//                master : control-path side (drives requests, sees responses)
//                slave  : alu_sched side (sees requests, drives responses)
//  Ports       : req_valid[1:0]  per-requester request, held until acked
//                req_op0/1[2:0]  macro-op of requester 0/1
//                req_a0/1, req_b0/1 [DW-1:0]  operands of requester 0/1
//                req_ack[1:0]    one-hot accept pulse
//                rsp_valid       1-cycle result strobe
//                rsp_id          requester owning the result
//                rsp_data[DW-1:0], rsp_zero, rsp_err
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_sched_if #(
    parameter int DW = 8
);
    logic [1:0]    req_valid;
    logic [2:0]    req_op0;
    logic [DW-1:0] req_a0;
    logic [DW-1:0] req_b0;
    logic [2:0]    req_op1;
    logic [DW-1:0] req_a1;
    logic [DW-1:0] req_b1;
    logic [1:0]    req_ack;
    logic          rsp_valid;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_zero;
    logic          rsp_err;

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        input  req_ack, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        output req_ack, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sched
//  Description : Shares one 2-bit-command ALU between two requesters
//                (0 = fetch/branch, 1 = execute) with round-robin arbitration.
//                Each accepted 3-bit macro-op is expanded into a sequence of
//                ALU passes (NAND/ROR/ADD/PASS); intermediates live in an
//                internal temp register and one result is returned per
//                accepted request.
//  Ports       : clk        system clock, rising edge
//                reset      asynchronous, active-high reset
//                bus        alu_sched_if.slave request/response bundle
//                alu_cmd    to alu: 00 NAND, 01 ROR, 10 ADD, 11 PASS
//                alu_a      to alu operand A
//                alu_b      to alu operand B
//                alu_rslt   from alu result
//  Config      : ALU_SCHED_MULTI_EN  defined   -> SUB (101) and OR (110)
//                                                 implemented (3 passes)
//                                    undefined -> 101/110 are illegal,
//                                                 no second temp register
//  Revision    : 1.0  initial release
// ============================================================================
module alu_sched #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    alu_sched_if.slave    bus,
    output logic [1:0]    alu_cmd,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_rslt
);

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ALU primitive commands
    localparam logic [1:0] c_CMD_NAND = 2'b00;
    localparam logic [1:0] c_CMD_ROR  = 2'b01;
    localparam logic [1:0] c_CMD_ADD  = 2'b10;
    localparam logic [1:0] c_CMD_PASS = 2'b11;

    // Macro-op encoding
    localparam logic [2:0] c_OP_NAND = 3'b000;
    localparam logic [2:0] c_OP_ROR  = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_PASS = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_SUB  = 3'b101;
    localparam logic [2:0] c_OP_OR   = 3'b110;
    localparam logic [2:0] c_OP_ILL  = 3'b111;

`ifdef ALU_SCHED_MULTI_EN
    // Up to three passes: pass index 0..2
    localparam int          c_PASS_W = 2;
    localparam logic [DW-1:0] c_ONE  = DW'(1);
`else
    // Up to two passes: pass index 0..1
    localparam int          c_PASS_W = 1;
`endif

    // ------------------------------------------------------------------------
    // Opcode helpers
    // ------------------------------------------------------------------------
    function automatic logic f_legal(input logic [2:0] op);
`ifdef ALU_SCHED_MULTI_EN
        return (op != c_OP_ILL);
`else
        return !((op == c_OP_ILL) || (op == c_OP_SUB) || (op == c_OP_OR));
`endif
    endfunction

    // Index of the final pass of a legal macro-op
    function automatic logic [c_PASS_W-1:0] f_last_pass(input logic [2:0] op);
        case (op)
            c_OP_AND: return c_PASS_W'(1);
`ifdef ALU_SCHED_MULTI_EN
            c_OP_SUB,
            c_OP_OR:  return c_PASS_W'(2);
`endif
            default:  return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_last_grant;
    logic                r_id;
    logic [2:0]          r_op;
    logic [DW-1:0]       r_a;
    logic [DW-1:0]       r_b;
    logic [DW-1:0]       r_temp;
`ifdef ALU_SCHED_MULTI_EN
    logic [DW-1:0]       r_temp2;
`endif
    logic [c_PASS_W-1:0] r_pass;

    logic                r_rsp_id;
    logic [DW-1:0]       r_rsp_data;
    logic                r_rsp_zero;
    logic                r_rsp_err;

    // ------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------------
    logic          w_grant;
    logic          w_grant_id;
    logic [2:0]    w_req_op;
    logic [DW-1:0] w_req_a;
    logic [DW-1:0] w_req_b;
    logic          w_last_pass;

    // Both requesting: alternate away from the previous winner.
    // Only one requesting: requester 1 wins exactly when requester 0 is idle.
    assign w_grant_id = (bus.req_valid == 2'b11) ? ~r_last_grant : ~bus.req_valid[0];
    // Reset is folded in so no accept pulse can escape while reset is held.
    assign w_grant    = (r_state == c_ST_IDLE) && (bus.req_valid != 2'b00) && !reset;

    assign w_req_op   = w_grant_id ? bus.req_op1 : bus.req_op0;
    assign w_req_a    = w_grant_id ? bus.req_a1  : bus.req_a0;
    assign w_req_b    = w_grant_id ? bus.req_b1  : bus.req_b0;

    assign w_last_pass = (r_pass == f_last_pass(r_op));

    assign bus.req_ack   = w_grant ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = (r_state == c_ST_DONE);
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
    assign bus.rsp_err   = r_rsp_err;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and ALU drive
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        alu_cmd      = c_CMD_PASS;
        alu_a        = '0;
        alu_b        = '0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    // Illegal ops skip EXEC and report an error next cycle
                    w_next_state = f_legal(w_req_op) ? c_ST_EXEC : c_ST_DONE;
                end
            end

            c_ST_EXEC: begin
                case (r_op)
                    c_OP_NAND: begin
                        alu_cmd = c_CMD_NAND;
                        alu_a   = r_a;
                        alu_b   = r_b;
                    end
                    c_OP_ROR: begin
                        alu_cmd = c_CMD_ROR;
                        alu_a   = r_a;
                        alu_b   = r_b;
                    end
                    c_OP_ADD: begin
                        alu_cmd = c_CMD_ADD;
                        alu_a   = r_a;
                        alu_b   = r_b;
                    end
                    c_OP_PASS: begin
                        alu_cmd = c_CMD_PASS;
                        alu_a   = r_a;
                        alu_b   = r_b;
                    end
                    c_OP_AND: begin
                        // t = NAND(A,B); result = NAND(t,t)
                        alu_cmd = c_CMD_NAND;
                        if (r_pass == '0) begin
                            alu_a = r_a;
                            alu_b = r_b;
                        end else begin
                            alu_a = r_temp;
                            alu_b = r_temp;
                        end
                    end
`ifdef ALU_SCHED_MULTI_EN
                    c_OP_SUB: begin
                        // Two's complement of B, then A + (-B)
                        case (r_pass)
                            2'd0: begin
                                alu_cmd = c_CMD_NAND;
                                alu_a   = r_b;
                                alu_b   = r_b;
                            end
                            2'd1: begin
                                alu_cmd = c_CMD_ADD;
                                alu_a   = r_temp;
                                alu_b   = c_ONE;
                            end
                            default: begin
                                alu_cmd = c_CMD_ADD;
                                alu_a   = r_a;
                                alu_b   = r_temp;
                            end
                        endcase
                    end
                    c_OP_OR: begin
                        // De Morgan: NAND(~A, ~B)
                        alu_cmd = c_CMD_NAND;
                        case (r_pass)
                            2'd0: begin
                                alu_a = r_a;
                                alu_b = r_a;
                            end
                            2'd1: begin
                                alu_a = r_b;
                                alu_b = r_b;
                            end
                            default: begin
                                alu_a = r_temp;
                                alu_b = r_temp2;
                            end
                        endcase
                    end
`endif
                    default: begin
                        // Illegal ops never reach EXEC
                    end
                endcase

                if (w_last_pass) begin
                    w_next_state = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end

            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, pass sequencing, temps and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_temp       <= '0;
`ifdef ALU_SCHED_MULTI_EN
            r_temp2      <= '0;
`endif
            r_pass       <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_op         <= w_req_op;
                r_a          <= w_req_a;
                r_b          <= w_req_b;
                r_pass       <= '0;
                if (!f_legal(w_req_op)) begin
                    // Error response is ready for the DONE cycle that follows
                    r_temp     <= '0;
                    r_rsp_id   <= w_grant_id;
                    r_rsp_data <= '0;
                    r_rsp_zero <= 1'b1;
                    r_rsp_err  <= 1'b1;
                end
            end

            if (r_state == c_ST_EXEC) begin
                r_pass <= r_pass + c_PASS_W'(1);
`ifdef ALU_SCHED_MULTI_EN
                // The middle OR pass produces ~B, kept apart from ~A
                if ((r_op == c_OP_OR) && (r_pass == c_PASS_W'(1))) begin
                    r_temp2 <= alu_rslt;
                end else begin
                    r_temp <= alu_rslt;
                end
`else
                r_temp <= alu_rslt;
`endif
                if (w_last_pass) begin
                    r_rsp_id   <= r_id;
                    r_rsp_data <= alu_rslt;
                    r_rsp_zero <= (alu_rslt == '0);
                    r_rsp_err  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
